i_mem_arb: RTL and testbench

Single-port arbiter that shares the gpc_4t instruction memory (i_mem_wrap) between the core fetch port and the fabric access port used for program load and debug readback. It sits between the core front-end, the fabric slave decode and i_mem_wrap. It grants at most one access per cycle, routes the 1-cycle-latency read data back to the owning requester, and guarantees the fabric bounded wait under continuous fetch.

---
 rtl/gpc_4t_pkg.sv | 26 ++
 rtl/i_mem_arb.sv | 114 +++++++++++
 tb/tb_i_mem_arb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gpc_4t_pkg.sv
// Shared types and defaults for the gpc_4t instruction-memory arbiter.
// Optional feature macro: I_MEM_ARB_LOCK_EN adds the FAB_LOCK state.
package gpc_4t_pkg;

  localparam int I_MEM_ARB_STARVE_MAX = 4;

`ifdef I_MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    CORE_PRI  = 2'd0,
    FAB_FORCE = 2'd1,
    FAB_LOCK  = 2'd2
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    CORE_PRI  = 2'd0,
    FAB_FORCE = 2'd1
  } arb_state_t;
`endif

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_FAB  = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/i_mem_arb.sv
// Single-port i_mem arbiter: core fetch vs fabric load/debug, starvation-bounded.
// Define I_MEM_ARB_LOCK_EN to add the fab_lock port and exclusive FAB_LOCK state.
module i_mem_arb
  import gpc_4t_pkg::*;
#(
  parameter int STARVE_MAX = I_MEM_ARB_STARVE_MAX,
  parameter int CNT_W      = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  output logic        core_gnt,
  output logic        core_rd_valid,
  output logic [31:0] core_rd_data,
  input  logic        fab_req,
  input  logic        fab_wr,
  input  logic [31:0] fab_addr,
  input  logic [31:0] fab_wr_data,
  output logic        fab_gnt,
  output logic        fab_rd_valid,
  output logic [31:0] fab_rd_data,
`ifdef I_MEM_ARB_LOCK_EN
  input  logic        fab_lock,
`endif
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_rden,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);

  arb_state_t             state_q, state_d;
  arb_owner_t             owner_q, owner_d;
  logic       [CNT_W-1:0] cnt_q, cnt_d;
  logic                   lock_act;

`ifdef I_MEM_ARB_LOCK_EN
  assign lock_act = fab_lock | (state_q == FAB_LOCK);
`else
  assign lock_act = 1'b0;
`endif

  always_comb begin
    core_gnt = 1'b0;
    fab_gnt  = 1'b0;
    case (state_q)
      FAB_FORCE: fab_gnt = fab_req;
`ifdef I_MEM_ARB_LOCK_EN
      FAB_LOCK:  fab_gnt = fab_req;
`endif
      default: begin
        core_gnt = core_req;
        fab_gnt  = fab_req & ~core_req;
      end
    endcase
    if (rst) begin
      core_gnt = 1'b0;
      fab_gnt  = 1'b0;
    end
  end

  // Counter counts lost fabric cycles; the FSM flips to FAB_FORCE on the edge
  // where it reaches STARVE_MAX so the grant lands STARVE_MAX cycles after req.
  always_comb begin
    cnt_d = '0;
    if (fab_req && !fab_gnt && !lock_act) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CORE_PRI:  if (cnt_d == CNT_W'(STARVE_MAX)) state_d = FAB_FORCE;
      FAB_FORCE: if (fab_gnt || !fab_req) state_d = CORE_PRI;
`ifdef I_MEM_ARB_LOCK_EN
      FAB_LOCK:  state_d = CORE_PRI;
`endif
      default:   state_d = CORE_PRI;
    endcase
`ifdef I_MEM_ARB_LOCK_EN
    if (fab_lock) state_d = FAB_LOCK;
`endif
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (core_gnt)                owner_d = OWN_CORE;
    else if (fab_gnt && !fab_wr) owner_d = OWN_FAB;
  end

  assign mem_address   = fab_gnt ? fab_addr : core_addr;
  assign mem_data      = fab_wr_data;
  assign mem_rden      = core_gnt | (fab_gnt & ~fab_wr);
  assign mem_wren      = fab_gnt & fab_wr;

  // Gating with rst kills a read that was in flight when reset arrived.
  assign core_rd_valid = ~rst & (owner_q == OWN_CORE);
  assign fab_rd_valid  = ~rst & (owner_q == OWN_FAB);
  assign core_rd_data  = mem_q;
  assign fab_rd_data   = mem_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= CORE_PRI;
      cnt_q   <= '0;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_i_mem_arb.sv
// Scoreboard bench for i_mem_arb with a behavioural 1-cycle-latency memory.
module tb_i_mem_arb;

  logic        clock = 1'b0;
  logic        rst;
  logic        core_req, core_gnt, core_rd_valid;
  logic [31:0] core_addr, core_rd_data;
  logic        fab_req, fab_wr, fab_gnt, fab_rd_valid;
  logic [31:0] fab_addr, fab_wr_data, fab_rd_data;
  logic [31:0] mem_address, mem_data, mem_q;
  logic        mem_rden, mem_wren;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] core_sb [$];
  logic [31:0] fab_sb  [$];
  logic        pend_core, pend_fab;
  int          n_chk = 0;
  int          n_err = 0;

  i_mem_arb #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clock(clock), .rst(rst),
    .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
    .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data),
    .fab_req(fab_req), .fab_wr(fab_wr), .fab_addr(fab_addr),
    .fab_wr_data(fab_wr_data), .fab_gnt(fab_gnt),
    .fab_rd_valid(fab_rd_valid), .fab_rd_data(fab_rd_data),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) mem[mem_address[9:2]] <= mem_data;
    if (mem_rden) mem_q <= mem[mem_address[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Read data is popped against the scoreboard whenever a valid appears.
  always @(negedge clock) begin
    if (core_rd_valid) begin
      if (core_sb.size() == 0) chk("core_rd_spurious", core_rd_valid, 0);
      else chk("core_rd_data", core_rd_data, core_sb.pop_front());
    end
    if (fab_rd_valid) begin
      if (fab_sb.size() == 0) chk("fab_rd_spurious", fab_rd_valid, 0);
      else chk("fab_rd_data", fab_rd_data, fab_sb.pop_front());
    end
  end

  task automatic cyc(input logic cr, input logic [31:0] ca,
                     input logic fr, input logic fw, input logic [31:0] fa,
                     input logic [31:0] fd, input logic exp_cg, input logic exp_fg);
    rst = 1'b0;
    core_req = cr; core_addr = ca;
    fab_req = fr; fab_wr = fw; fab_addr = fa; fab_wr_data = fd;
    #1;
    chk("core_gnt", core_gnt, exp_cg);
    chk("fab_gnt", fab_gnt, exp_fg);
    chk("core_rd_valid", core_rd_valid, pend_core);
    chk("fab_rd_valid", fab_rd_valid, pend_fab);
    chk("mem_rden", mem_rden, exp_cg | (exp_fg & ~fw));
    chk("mem_wren", mem_wren, exp_fg & fw);
    if (!exp_cg && !exp_fg) chk("mem_addr_idle", mem_address, ca);
    pend_core = exp_cg;
    pend_fab  = exp_fg & ~fw;
    if (exp_cg) core_sb.push_back(ref_mem[ca[9:2]]);
    if (exp_fg) begin
      if (fw) ref_mem[fa[9:2]] = fd;
      else    fab_sb.push_back(ref_mem[fa[9:2]]);
    end
    @(posedge clock); #1;
  endtask

  task automatic rst_cyc();
    logic [31:0] drop;
    rst = 1'b1;
    core_req = 1'b1; core_addr = 32'h4;
    fab_req = 1'b1; fab_wr = 1'b0; fab_addr = 32'h8;
    #1;
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_fab_gnt", fab_gnt, 0);
    chk("rst_core_rd_valid", core_rd_valid, 0);
    chk("rst_fab_rd_valid", fab_rd_valid, 0);
    chk("rst_mem_rden", mem_rden, 0);
    chk("rst_mem_wren", mem_wren, 0);
    if (pend_core) drop = core_sb.pop_back();
    if (pend_fab)  drop = fab_sb.pop_back();
    pend_core = 1'b0;
    pend_fab  = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 ^ (i * 32'h0101_0103);
      ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0103);
    end
    pend_core = 1'b0; pend_fab = 1'b0;
    rst = 1'b1; core_req = 1'b0; core_addr = '0;
    fab_req = 1'b0; fab_wr = 1'b0; fab_addr = '0; fab_wr_data = '0;
    @(posedge clock); #1;
    rst_cyc();
    rst_cyc();

    // Core-only stream.
    for (int i = 0; i < 10; i++) cyc(1, 32'(i * 4), 0, 0, 0, 0, 1, 0);
    cyc(0, 32'h3C, 0, 0, 0, 0, 0, 0);

    // Fabric load, then core and fabric readback.
    cyc(0, 32'h3C, 1, 1, 32'h40, 32'hDEADBEEF, 0, 1);
    cyc(1, 32'h40, 0, 0, 0, 0, 1, 0);
    cyc(0, 32'h0, 1, 0, 32'h40, 0, 0, 1);
    cyc(0, 32'h3C, 0, 0, 0, 0, 0, 0);

    // Starvation twice in a row: second run shows the counter restarted.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++)
        cyc(1, 32'h100 + 32'(c * 4), 1, 0, 32'h80 + 32'(r * 4), 0, 1, 0);
      cyc(1, 32'h110, 1, 0, 32'h80 + 32'(r * 4), 0, 0, 1);
    end
    cyc(1, 32'h114, 0, 0, 0, 0, 1, 0);
    cyc(0, 32'h3C, 0, 0, 0, 0, 0, 0);

    // Interleaved owners back to back.
    cyc(1, 32'h08, 0, 0, 0, 0, 1, 0);
    cyc(0, 32'h0, 1, 0, 32'hC0, 0, 0, 1);
    cyc(1, 32'h0C, 0, 0, 0, 0, 1, 0);
    cyc(0, 32'h3C, 0, 0, 0, 0, 0, 0);

    // Reset while a core read is outstanding.
    cyc(1, 32'h20, 0, 0, 0, 0, 1, 0);
    rst_cyc();
    rst_cyc();
    cyc(0, 32'h3C, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h24, 1, 0, 32'h88, 0, 1, 0);
    cyc(0, 32'h3C, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h3C, 0, 0, 0, 0, 0, 0);

    chk("core_sb_empty", core_sb.size(), 0);
    chk("fab_sb_empty", fab_sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
